seq_display_counter: RTL and testbench
======================================

Name: seq_display_counter

Overview:
- Parametrised successor to the fixed 9-step up/down display sequencer.
- Steps an index through a DEPTH-entry table of DATA_W-bit display codes.
- UP/DOWN commands step the index; both together blank the display.
- The table is runtime-writable and resets to the default digit sequence 6,9,0,2,4,6,5,3,8.
- Adds a step qualifier, wrap/saturate mode, wrap pulse and index output.
- Sits between the button/debounce logic and the 7-segment decoder.

Parameters:
- DEPTH, 9, number of table entries (2..16).
- DATA_W, 4, width of each display code.
- IDX_W, 4, index width; must satisfy 2^IDX_W >= DEPTH.
- BLANK_CODE, 4'hF, code driven on z while blanked.
- WRAP, 1, 1 = wrap at the ends, 0 = saturate at the ends.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- step_en  in  1  command qualifier; commands are acted on only in cycles where this is 1.
- UP  in  1  step-up command.
- DOWN  in  1  step-down command.
- wr_en  in  1  table write strobe.
- wr_addr  in  IDX_W  table write address.
- wr_data  in  DATA_W  table write data.
- z  out  DATA_W  current display code.
- idx  out  IDX_W  current table index.
- blank  out  1  1 while in BLANK state.
- wrap  out  1  one-cycle pulse when the index wraps.

Behaviour:
- Reset is asynchronous, active-low; on assertion:
  - state=RUN, idx=0, wrap=0, blank=0.
  - Table restored to defaults: entries 0..8 = 6,9,0,2,4,6,5,3,8; entries >=9 = 0.
  - z therefore = 6 while reset is asserted and after release.
- States are RUN and BLANK; transitions happen only in cycles with an accepted command (step_en=1, evaluated at the clock edge).
- RUN transitions:
  - UP&!DOWN: idx+1. At DEPTH-1: WRAP=1 -> idx=0 and wrap=1 next cycle; WRAP=0 -> hold DEPTH-1, no pulse.
  - DOWN&!UP: idx-1. At 0: WRAP=1 -> idx=DEPTH-1 with wrap pulse; WRAP=0 -> hold 0.
  - UP&DOWN: go to BLANK; idx holds.
  - Neither: hold.
- BLANK transitions:
  - UP&!DOWN -> RUN, idx=0.
  - DOWN&!UP -> RUN, idx=DEPTH-1.
  - Both or neither: stay in BLANK.
  - No wrap pulse on leaving BLANK.
- Outputs:
  - z = table[idx] in RUN, BLANK_CODE in BLANK. Combinational from registered state and table, so the new index is visible one cycle after the accepting edge.
  - blank = (state==BLANK).
  - wrap is registered and high for exactly one cycle.
- Table writes:
  - Synchronous write when wr_en=1.
  - wr_addr >= DEPTH is ignored.
  - A write to the current idx is visible on z the cycle after the edge.
  - Writes are independent of state and of command stepping in the same cycle.
- Illegal internal state or idx >= DEPTH recovers to RUN, idx=0 on the next clock edge.
- Reset mid-operation aborts any command and restores the table defaults.

Optional Feature:
- Macro: SEQ_INPUT_EDGE_EN.
- Defined:
  - UP and DOWN each pass through a 2-flop synchroniser plus a rising-edge detector.
  - A command is the edge pulse, still qualified by step_en; a held button steps exactly once.
  - UP&DOWN counts as "both" only when both edges occur in the same cycle.
  - Adds 2 cycles of command latency.
  - Sync flops reset to 0.
- Undefined: UP and DOWN are used as levels, sampled in every cycle where step_en=1.

Decomposition:
- Package seq_display_pkg contains:
  - the state encoding (RUN, BLANK);
  - the default table constant (6,9,0,2,4,6,5,3,8);
  - the default BLANK_CODE.
- Sub-module seq_input_cond (synchroniser + edge detect, one per input), instantiated only under SEQ_INPUT_EDGE_EN.

Test Plan:
- Reset release, step_en=1, UP held 9 cycles (level mode) -> z = 9,0,2,4,6,5,3,8,6; wrap=1 only in the cycle idx returns to 0.
- From idx=0: DOWN one cycle -> idx=8, z=8, wrap pulse. Repeat with WRAP=0 -> idx stays 0, z=6, no pulse.
- At idx=3, UP=DOWN=1 -> blank=1, z=15, idx=3. Then DOWN -> RUN, idx=8, z=8. Then UP&DOWN, then UP -> idx=0, z=6.
- At idx=2: write wr_addr=2, wr_data=7 -> z=7 next cycle. Write wr_addr=12 (DEPTH=9) -> ignored. Reset -> entry 2 back to 0, z=6.
- step_en=0 with UP toggling for 10 cycles -> idx unchanged. Reset asserted mid-sequence at idx=5 -> idx=0 immediately, asynchronously.
- SEQ_INPUT_EDGE_EN defined, UP held 20 cycles -> exactly one step, z 6->9 after 3 cycles.

Source files
------------

// File: rtl/seq_display_pkg.sv
// seq_display_pkg: state encoding, default display table and default blank code
//   RUN/BLANK are one-hot so a corrupted state register is detectable.
package seq_display_pkg;
    typedef enum logic [1:0] {RUN = 2'b01, BLANK = 2'b10} state_t;
    localparam int DEF_LEN = 9;
    // Entry 0 is the rightmost nibble: 6,9,0,2,4,6,5,3,8
    localparam logic [DEF_LEN-1:0][3:0] DEF_TABLE = {4'd8, 4'd3, 4'd5, 4'd6, 4'd4, 4'd2, 4'd0, 4'd9, 4'd6};
    localparam logic [3:0] DEF_BLANK_CODE = 4'hF;
    function automatic logic [3:0] def_code(input int i);
        logic [3:0] v;
        v = 4'd0;
        for (int k = 0; k < DEF_LEN; k++)
            if (k == i) v = DEF_TABLE[k];
        return v;
    endfunction
endpackage

// File: rtl/seq_input_cond.sv
// seq_input_cond: 2-flop synchroniser plus rising-edge detector for one button
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (flops clear to 0)
//   i_in     raw asynchronous level
//   o_pulse  one-cycle pulse on a synchronised rising edge
module seq_input_cond (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_pulse
);
    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_in};
            r_prev <= r_sync[1];
        end
    end

    assign o_pulse = r_sync[1] & ~r_prev;
endmodule

// File: rtl/seq_display_counter.sv
// seq_display_counter: steps an index through a writable display-code table
//   clock    rising-edge clock
//   reset    asynchronous active-low reset (restores table defaults)
//   step_en  qualifies UP/DOWN commands
//   UP/DOWN  step commands; both together blank the display
//   wr_en/wr_addr/wr_data  synchronous table write (addresses >= DEPTH ignored)
//   z        table[idx] in RUN, BLANK_CODE in BLANK
//   idx      current index
//   blank    high in BLANK state
//   wrap     registered one-cycle pulse when the index wraps
// Build option SEQ_INPUT_EDGE_EN: UP/DOWN are synchronised and edge-detected
// so a held button steps once (adds 2 cycles of command latency).
module seq_display_counter
    import seq_display_pkg::*;
#(
    parameter int                DEPTH      = 9,
    parameter int                DATA_W     = 4,
    parameter int                IDX_W      = 4,
    parameter logic [DATA_W-1:0] BLANK_CODE = DATA_W'(DEF_BLANK_CODE),
    parameter bit                WRAP       = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step_en,
    input  logic              UP,
    input  logic              DOWN,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] z,
    output logic [IDX_W-1:0]  idx,
    output logic              blank,
    output logic              wrap
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_table [DEPTH];
    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_wrap;
    logic              w_up;
    logic              w_down;
    logic              w_idx_ok;
    logic              w_state_ok;

`ifdef SEQ_INPUT_EDGE_EN
    seq_input_cond u_up   (.i_clk(clock), .i_rst_n(reset), .i_in(UP),   .o_pulse(w_up));
    seq_input_cond u_down (.i_clk(clock), .i_rst_n(reset), .i_in(DOWN), .o_pulse(w_down));
`else
    assign w_up   = UP;
    assign w_down = DOWN;
`endif

    assign w_idx_ok   = int'(r_idx) < DEPTH;
    assign w_state_ok = (r_state == RUN) || (r_state == BLANK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= DATA_W'(def_code(i));
        end else if (wr_en && int'(wr_addr) < DEPTH) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (!w_state_ok || !w_idx_ok) begin
                r_state <= RUN;
                r_idx   <= '0;
            end else if (step_en && (w_up || w_down)) begin
                if (r_state == BLANK) begin
                    if (w_up != w_down) begin
                        r_state <= RUN;
                        r_idx   <= w_up ? '0 : LAST;
                    end
                end else if (w_up && w_down) begin
                    r_state <= BLANK;
                end else if (w_up) begin
                    if (r_idx != LAST) r_idx <= r_idx + 1'b1;
                    else if (WRAP) begin
                        r_idx  <= '0;
                        r_wrap <= 1'b1;
                    end
                end else begin
                    if (r_idx != '0) r_idx <= r_idx - 1'b1;
                    else if (WRAP) begin
                        r_idx  <= LAST;
                        r_wrap <= 1'b1;
                    end
                end
            end
        end
    end

    assign z     = (r_state == BLANK) ? BLANK_CODE : (w_idx_ok ? r_table[r_idx] : '0);
    assign idx   = r_idx;
    assign blank = r_state == BLANK;
    assign wrap  = r_wrap;
endmodule

// File: tb/tb_seq_display_counter.sv
// tb_seq_display_counter: random and directed checks of a wrapping and a saturating instance
module tb_seq_display_counter;
    localparam int DEPTH = 9;
    localparam int DW    = 4;
    localparam int IW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          step_en = 1'b0;
    logic          UP = 1'b0;
    logic          DOWN = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] z_w, z_s;
    logic [IW-1:0] idx_w, idx_s;
    logic          blank_w, blank_s, wrap_w, wrap_s;

    int tests = 0;
    int fails = 0;
    bit check_on = 1'b0;

    always #5 clock = ~clock;

    seq_display_counter #(.DEPTH(DEPTH), .DATA_W(DW), .IDX_W(IW), .BLANK_CODE(4'hF), .WRAP(1'b1)) dut_w (
        .clock(clock), .reset(reset), .step_en(step_en), .UP(UP), .DOWN(DOWN),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .z(z_w), .idx(idx_w), .blank(blank_w), .wrap(wrap_w));

    seq_display_counter #(.DEPTH(DEPTH), .DATA_W(DW), .IDX_W(IW), .BLANK_CODE(4'hF), .WRAP(1'b0)) dut_s (
        .clock(clock), .reset(reset), .step_en(step_en), .UP(UP), .DOWN(DOWN),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .z(z_s), .idx(idx_s), .blank(blank_s), .wrap(wrap_s));

    // Reference model: index 0 = wrapping instance, 1 = saturating instance
    int m_idx [2];
    bit m_blank [2];
    bit m_wrap [2];
    int m_tab [2][16];
    bit uh [4];
    bit dh [4];
    int def [9] = '{6, 9, 0, 2, 4, 6, 5, 3, 8};

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0;
            m_blank[k] = 1'b0;
            m_wrap[k] = 1'b0;
            for (int i = 0; i < 16; i++) m_tab[k][i] = (i < 9) ? def[i] : 0;
        end
        for (int i = 0; i < 4; i++) begin
            uh[i] = 1'b0;
            dh[i] = 1'b0;
        end
    endtask

    task automatic m_step();
        bit cu, cd;
        for (int i = 3; i > 0; i--) begin
            uh[i] = uh[i-1];
            dh[i] = dh[i-1];
        end
        uh[0] = UP;
        dh[0] = DOWN;
`ifdef SEQ_INPUT_EDGE_EN
        cu = uh[2] & ~uh[3];
        cd = dh[2] & ~dh[3];
`else
        cu = UP;
        cd = DOWN;
`endif
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (step_en && (cu || cd)) begin
                if (m_blank[k]) begin
                    if (cu != cd) begin
                        m_blank[k] = 1'b0;
                        m_idx[k] = cu ? 0 : DEPTH - 1;
                    end
                end else if (cu && cd) begin
                    m_blank[k] = 1'b1;
                end else if (k == 0) begin
                    m_wrap[k] = cu ? (m_idx[k] == DEPTH - 1) : (m_idx[k] == 0);
                    m_idx[k] = (m_idx[k] + (cu ? 1 : DEPTH - 1)) % DEPTH;
                end else begin
                    m_idx[k] = cu ? ((m_idx[k] < DEPTH - 1) ? m_idx[k] + 1 : m_idx[k])
                                  : ((m_idx[k] > 0) ? m_idx[k] - 1 : 0);
                end
            end
            if (wr_en && int'(wr_addr) < DEPTH) m_tab[k][wr_addr] = int'(wr_data);
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (check_on) begin
                chk("z_wrap", int'(z_w), m_blank[0] ? 15 : m_tab[0][m_idx[0]]);
                chk("idx_wrap", int'(idx_w), m_idx[0]);
                chk("blank_wrap", int'(blank_w), int'(m_blank[0]));
                chk("wrap_wrap", int'(wrap_w), int'(m_wrap[0]));
                chk("z_sat", int'(z_s), m_blank[1] ? 15 : m_tab[1][m_idx[1]]);
                chk("idx_sat", int'(idx_s), m_idx[1]);
                chk("blank_sat", int'(blank_s), int'(m_blank[1]));
                chk("wrap_sat", int'(wrap_s), int'(m_wrap[1]));
            end
        end
    end

    task automatic step(input bit u, input bit d, input bit e);
        UP = u;
        DOWN = d;
        step_en = e;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

`ifndef SEQ_INPUT_EDGE_EN
    int seq_w [9] = '{9, 0, 2, 4, 6, 5, 3, 8, 6};
    int seq_s [9] = '{9, 0, 2, 4, 6, 5, 3, 8, 8};
`endif

    initial begin
        check_on = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("reset_z", int'(z_w), 6);
        chk("reset_idx", int'(idx_w), 0);
        reset = 1'b1;
`ifndef SEQ_INPUT_EDGE_EN
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1);
            chk("up_seq_z_wrap", int'(z_w), seq_w[i]);
            chk("up_seq_wrap", int'(wrap_w), (i == 8) ? 1 : 0);
            chk("up_seq_z_sat", int'(z_s), seq_s[i]);
            chk("up_seq_wrap_sat", int'(wrap_s), 0);
        end
        do_reset();
        step(0, 1, 1);
        chk("down_wrap_idx", int'(idx_w), 8);
        chk("down_wrap_z", int'(z_w), 8);
        chk("down_wrap_pulse", int'(wrap_w), 1);
        chk("down_sat_idx", int'(idx_s), 0);
        chk("down_sat_z", int'(z_s), 6);
        chk("down_sat_pulse", int'(wrap_s), 0);
        step(0, 0, 1);
        chk("wrap_one_cycle", int'(wrap_w), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        chk("at_idx3", int'(idx_w), 3);
        step(1, 1, 1);
        chk("blank_on", int'(blank_w), 1);
        chk("blank_z", int'(z_w), 15);
        chk("blank_idx", int'(idx_w), 3);
        step(0, 1, 1);
        chk("unblank_down_idx", int'(idx_w), 8);
        chk("unblank_down_z", int'(z_w), 8);
        chk("unblank_no_wrap", int'(wrap_w), 0);
        step(1, 1, 1);
        step(1, 0, 1);
        chk("unblank_up_idx", int'(idx_w), 0);
        chk("unblank_up_z", int'(z_w), 6);
        step(1, 0, 1);
        step(1, 0, 1);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'd7;
        step(0, 0, 1);
        chk("write_cur_z", int'(z_w), 7);
        wr_addr = 4'd12; wr_data = 4'd1;
        step(0, 0, 1);
        wr_en = 1'b0;
        step(1, 0, 1);
        step(1, 0, 1);
        chk("ignored_write_z4", int'(z_w), 4);
        do_reset();
        step(1, 0, 1);
        step(1, 0, 1);
        chk("reset_restores_tab", int'(z_w), 0);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 0, 0);
        chk("step_en_low_idx", int'(idx_w), 2);
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        chk("at_idx5", int'(idx_w), 5);
        step(0, 0, 1);
        #2 reset = 1'b0;
        #1 chk("async_reset_idx", int'(idx_w), 0);
        chk("async_reset_z", int'(z_w), 6);
        @(negedge clock);
        reset = 1'b1;
`else
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1);
            chk("edge_held_z", int'(z_w), (i < 2) ? 6 : 9);
        end
        step(0, 0, 1);
`endif
        for (int n = 0; n < 3000; n++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = IW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            else reset = 1'b1;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        reset = 1'b1;
        step(0, 0, 0);
        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
